// File: rtl/duck_pkg.sv
// Shared duck sprite definitions: life-cycle states and screen/sprite geometry
// used by the controller, the draw stage and the duck ROM sizing.
package duck_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    HIT  = 2'd2,
    FALL = 2'd3
  } duck_state_t;

  localparam int unsigned SCREEN_W = 1024;
  localparam int unsigned DUCK_W   = 96;
  localparam int unsigned DUCK_H   = 60;
  localparam int unsigned GROUND_Y = 600;

  localparam int unsigned POS_W  = 11;
  localparam int unsigned CALC_W = 12;

endpackage

// File: rtl/duck_ctl.sv
// Duck motion and life-cycle controller: spawn, per-frame flight with wall
// bounce and climb, hit freeze, fall, and escape/down reporting.
module duck_ctl #(
  parameter int unsigned SCREEN_W   = duck_pkg::SCREEN_W,
  parameter int unsigned DUCK_W     = duck_pkg::DUCK_W,
  parameter int unsigned DUCK_H     = duck_pkg::DUCK_H,
  parameter int unsigned GROUND_Y   = duck_pkg::GROUND_Y,
  parameter int unsigned HIT_FRAMES = 30,
  parameter int unsigned FALL_SPEED = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [10:0] start_x,
  input  logic        start_dir,
  input  logic [3:0]  speed,
  input  logic        shot_hit,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        duck_killed,
  output logic        active,
  output logic        duck_escaped,
  output logic        duck_down
);

  import duck_pkg::*;

  localparam int unsigned CNT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
  localparam logic [CALC_W-1:0] X_MAX  = CALC_W'(SCREEN_W - DUCK_W);
  localparam logic [CALC_W-1:0] Y_REST = CALC_W'(GROUND_Y - DUCK_H);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HIT_FRAMES - 1);

  duck_state_t        state, state_n;
  logic               dir, dir_n;
  logic [3:0]         spd, spd_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [POS_W-1:0]   x_n, y_n;
  logic               esc_n, down_n;
  logic [CALC_W-1:0]  x_sum, y_fall;

  // State and all outputs registered; outputs follow the next-state values
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dir          <= 1'b0;
      spd          <= '0;
      cnt          <= '0;
      xpos         <= '0;
      ypos         <= '0;
      active       <= 1'b0;
      duck_killed  <= 1'b0;
      duck_escaped <= 1'b0;
      duck_down    <= 1'b0;
    end else begin
      state        <= state_n;
      dir          <= dir_n;
      spd          <= spd_n;
      cnt          <= cnt_n;
      xpos         <= x_n;
      ypos         <= y_n;
      active       <= (state_n != IDLE);
      duck_killed  <= (state_n == HIT) || (state_n == FALL);
      duck_escaped <= esc_n;
      duck_down    <= down_n;
    end
  end

  // Next-state and next-position logic; all arithmetic in 12 bits, clamped before storing
  always_comb begin
    state_n = state;
    dir_n   = dir;
    spd_n   = spd;
    cnt_n   = cnt;
    x_n     = xpos;
    y_n     = ypos;
    esc_n   = 1'b0;
    down_n  = 1'b0;
    x_sum   = {1'b0, xpos} + CALC_W'(spd);
    y_fall  = {1'b0, ypos} + CALC_W'(FALL_SPEED);

    case (state)
      IDLE: begin
        if (start) begin
          x_n     = ({1'b0, start_x} > X_MAX) ? POS_W'(X_MAX) : start_x;
          y_n     = POS_W'(Y_REST);
          dir_n   = start_dir;
          spd_n   = speed;
          state_n = FLY;
        end
      end
      FLY: begin
        if (shot_hit) begin
          cnt_n   = '0;
          state_n = HIT;
        end else if (frame_tick) begin
          if (dir) begin
            if (x_sum >= X_MAX) begin
              x_n   = POS_W'(X_MAX);
              dir_n = 1'b0;
            end else begin
              x_n = x_sum[POS_W-1:0];
            end
          end else if ({1'b0, xpos} < CALC_W'(spd)) begin
            x_n   = '0;
            dir_n = 1'b1;
          end else begin
            x_n = xpos - POS_W'(spd);
          end
          if ({1'b0, ypos} <= CALC_W'(spd)) begin
            y_n     = '0;
            esc_n   = 1'b1;
            state_n = IDLE;
          end else begin
            y_n = ypos - POS_W'(spd);
          end
        end
      end
      HIT: begin
        if (frame_tick) begin
          if (cnt == CNT_LAST) begin
            state_n = FALL;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      FALL: begin
        if (frame_tick) begin
          if (y_fall >= Y_REST) begin
            y_n     = POS_W'(Y_REST);
            down_n  = 1'b1;
            state_n = IDLE;
          end else begin
            y_n = y_fall[POS_W-1:0];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
